instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Writer-side counterpart of the instruction memory read port.
- Accepts a byte stream from a host link (e.g. a UART receiver) through a valid/ready handshake.
- Packs the bytes little-endian into 32-bit instructions and drives the instruction memory write port at word-aligned byte addresses.
- Holds `busy` high for the whole load so top level can keep the core in reset until the program is in place.

Parameters:
- INS_ADDRESS, 9: byte-address width of the instruction memory. Depth = 2**(INS_ADDRESS-2) words; 128 at default.
- INS_W, 32: instruction width. Fixed at 4 bytes per word.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- num_words  in  INS_ADDRESS-1  number of instructions to load (0..255).
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts byte this cycle.
- wr_en  out  1  instruction memory write strobe.
- wa  out  INS_ADDRESS  write byte address; bits [1:0] always 0.
- wd  out  INS_W  write data.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at load completion.
- err  out  1  num_words exceeded depth; sticky until next accepted start.

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE.
  - byte_ready, wr_en, busy, done, err = 0; wa = 0; wd = 0.
  - Internal byte count, word index and target = 0.
- States: IDLE, LOAD, WRITE, DONE. `busy` = (state != IDLE). Registered outputs, no combinational path from inputs to outputs.
- IDLE:
  - byte_ready = 0.
  - On start = 1: target = min(num_words, DEPTH); err = (num_words > DEPTH); word index = 0; byte count = 0.
  - If num_words = 0, go to DONE; otherwise go to LOAD.
- LOAD:
  - byte_ready = 1.
  - A byte is accepted when byte_valid && byte_ready. Accepted byte k (0..3) goes to word bits [8k+7:8k].
  - On the 4th accepted byte, go to WRITE.
- WRITE (exactly one cycle):
  - wr_en = 1, wa = word_index << 2, wd = assembled word, byte_ready = 0.
  - Next cycle: word_index++ and byte count clears.
  - If word_index+1 == target, go to DONE; else go to LOAD.
- DONE (one cycle): done = 1, then go to IDLE.
- Latency:
  - 4th byte accepted in cycle n → wr_en in cycle n+1.
  - Next byte can be accepted no earlier than n+2.
  - Last write in cycle m → done in m+1 → busy low in m+2.
- Boundary conditions:
  - start while busy is ignored; target and err are unchanged.
  - byte_valid outside LOAD is not accepted. The host must hold byte_valid and byte_data stable until it sees byte_ready.
  - Overflow (num_words > DEPTH): exactly DEPTH writes, last wa = (DEPTH-1)*4; err stays 1 through DONE and IDLE.
  - Word index never wraps, since target ≤ DEPTH.
  - Reset asserted mid-load: immediate abort. No further wr_en; a partially assembled word is discarded; memory keeps the words already written.
- wd and wa hold their last written values outside WRITE. Only wr_en qualifies them.

Decomposition:
- Package instr_loader_pkg:
  - state_t enum {IDLE, LOAD, WRITE, DONE}.
  - BYTES_PER_WORD = 4.
  - Depth derivation function from INS_ADDRESS.
- Sub-module byte_packer: 2-bit byte counter plus 32-bit shift/insert register, with a clear input and a word_full output.
- The FSM, address counter and err logic stay in instr_mem_loader.

Test Plan:
- Basic load, 2 words:
  - Stimulus: num_words = 2; bytes 33 70 00 00 13 82 40 00, byte_valid held high.
  - Response: wr_en at wa = 0x000 with wd = 0x00007033; wr_en at wa = 0x004 with wd = 0x00408213; done one cycle after the 2nd write; busy low the cycle after done.
- Zero-length load:
  - Stimulus: num_words = 0, start in cycle t.
  - Response: done = 1 in t+1, no wr_en, err = 0, busy low in t+2.
- Overflow:
  - Stimulus: num_words = 200; stream 800 bytes.
  - Response: err = 1 from t+1; exactly 128 writes; last wa = 0x1FC; done after the 128th write; byte_ready = 0 afterwards.
- Backpressure and gaps:
  - Stimulus: byte_valid toggling 1-0-1 per cycle; a byte presented during WRITE.
  - Response: byte not accepted during WRITE (byte_ready = 0); held byte accepted in the following LOAD cycle; word contents correct and byte order preserved.
- Reset mid-load:
  - Stimulus: assert rst_n = 0 after 2 bytes of word 1.
  - Response: all outputs 0 asynchronously; no wr_en.
  - Follow-up: new start with num_words = 1 and bytes 93 00 10 00 → wa = 0x000, wd = 0x00100093.
- Start while busy:
  - Stimulus: 2nd start with num_words = 5 during a num_words = 1 load.
  - Response: ignored; only 1 write, then done.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction memory loader
package instr_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // Word depth of an instruction memory addressed by a byte address of addr_w bits.
    function automatic int unsigned words_for_addr(input int unsigned addr_w);
        return 32'd1 << (addr_w - 2);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles accepted bytes little-endian into one instruction word
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [7:0]        byte_i,
    output logic              word_full_o,
    output logic [WORD_W-1:0] word_next_o
);

    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0]     data_q, data_d;

    // word_next_o is the word as it will look once the current byte lands,
    // so the caller can capture a complete word on the same edge as the last byte.
    always_comb begin
        word_next_o = data_q;
        word_next_o[{cnt_q, 3'b000} +: 8] = byte_i;
    end

    assign word_full_o = accept_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clear_i) begin
            cnt_d  = '0;
            data_d = '0;
        end else if (accept_i) begin
            cnt_d  = cnt_q + BYTE_CNT_W'(1);
            data_d = word_next_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a host byte stream into instruction memory, one word per write
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned INS_ADDRESS = 9,
    parameter int unsigned INS_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [INS_ADDRESS-2:0] num_words,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   wr_en,
    output logic [INS_ADDRESS-1:0] wa,
    output logic [INS_W-1:0]       wd,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned   CW      = INS_ADDRESS - 1;
    localparam int unsigned   DEPTH   = words_for_addr(INS_ADDRESS);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t                 state_q, state_d;
    logic [CW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          target_q, target_d;
    logic                   err_q, err_d;
    logic [INS_ADDRESS-1:0] wa_q, wa_d;
    logic [INS_W-1:0]       wd_q, wd_d;

    logic                   accept;
    logic                   pk_clear;
    logic                   pk_full;
    logic [INS_W-1:0]       pk_next;

    // Outputs decode registered state only; nothing flows from inputs to outputs.
    assign byte_ready = (state_q == LOAD);
    assign wr_en      = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign wa         = wa_q;
    assign wd         = wd_q;

    assign accept   = byte_valid && (state_q == LOAD);
    assign pk_clear = (state_q == WRITE) || (state_q == IDLE);

    byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (pk_clear),
        .accept_i    (accept),
        .byte_i      (byte_data),
        .word_full_o (pk_full),
        .word_next_o (pk_next)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        target_d = target_q;
        err_d    = err_q;
        wa_d     = wa_q;
        wd_d     = wd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = (num_words > DEPTH_C) ? DEPTH_C : num_words;
                    err_d    = (num_words > DEPTH_C);
                    idx_d    = '0;
                    state_d  = (num_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                // Capture address and data on the last byte so they are valid during WRITE.
                if (pk_full) begin
                    wd_d    = pk_next;
                    wa_d    = {idx_q[INS_ADDRESS-3:0], 2'b00};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d   = idx_q + CW'(1);
                state_d = ((idx_q + CW'(1)) == target_q) ? DONE : LOAD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            err_q    <= err_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

endmodule
